// File: rtl/median_pkg.sv
// Shared types and sizing helpers for the sequential median filter.
package median_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int N_DEF     = 9;

  typedef logic [WIDTH_DEF-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SORT = 2'd2,
    OUT  = 2'd3
  } state_t;

  // Each pass strips the current maximum; the last pass's maximum is the median.
  function automatic int n_passes(input int n);
    return (n + 1) / 2;
  endfunction

endpackage

// File: rtl/MCE.sv
// Unsigned compare-exchange element: routes the larger operand to MAX and the smaller to MIN.
module MCE #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] MAX,
  output logic [WIDTH-1:0] MIN
);

  logic a_ge_b;

  // Ties pass both operands straight through, so equal values are never altered.
  assign a_ge_b = (A >= B);
  assign MAX    = a_ge_b ? A : B;
  assign MIN    = a_ge_b ? B : A;

endmodule

// File: rtl/median_seq.sv
// Sequential N-sample median filter built around a single MCE compare-exchange unit.
// Optional macro MEDIAN_ERR_EN adds an ERR pulse for early aborts and DSI seen during SORT.
module median_seq
  import median_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int N     = N_DEF
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] DI,
  input  logic             DSI,
  output logic [WIDTH-1:0] DO,
  output logic             DSO
`ifdef MEDIAN_ERR_EN
  ,
  output logic             ERR
`endif
);

  localparam int P  = n_passes(N);
  localparam int CW = $clog2(N + 1);
  localparam int PW = $clog2(P + 1);
  localparam logic [CW-1:0] LAST_IDX  = CW'(N - 1);
  localparam logic [PW-1:0] LAST_PASS = PW'(P - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    pass_q, pass_d;
  logic             got_q, got_d;
  logic             armed_q, armed_d;
  logic             dso_q, dso_d;
  logic [WIDTH-1:0] cmp_q, cmp_d;
  logic [WIDTH-1:0] do_q, do_d;
  logic [WIDTH-1:0] win_q [N];
  logic [WIDTH-1:0] win_d [N];
  logic [N-1:0]     live_q, live_d;

  logic             shift_en;
  logic [WIDTH-1:0] tail_val;
  logic             tail_live;
  logic [WIDTH-1:0] mce_max, mce_min;

`ifdef MEDIAN_ERR_EN
  logic err_q, err_d;
`endif

  MCE #(.WIDTH(WIDTH)) u_mce (
    .A   (win_q[0]),
    .B   (cmp_q),
    .MAX (mce_max),
    .MIN (mce_min)
  );

  // Window is a shift register: samples enter at the tail, SORT rotates head back to tail.
  genvar gi;
  generate
    for (gi = 0; gi < N - 1; gi++) begin : g_win
      assign win_d[gi]  = shift_en ? win_q[gi + 1]  : win_q[gi];
      assign live_d[gi] = shift_en ? live_q[gi + 1] : live_q[gi];
    end
  endgenerate

  assign win_d[N-1]  = shift_en ? tail_val  : win_q[N-1];
  assign live_d[N-1] = shift_en ? tail_live : live_q[N-1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    got_d     = got_q;
    armed_d   = armed_q;
    cmp_d     = cmp_q;
    do_d      = do_q;
    dso_d     = 1'b0;
    shift_en  = 1'b0;
    tail_val  = DI;
    tail_live = 1'b1;
`ifdef MEDIAN_ERR_EN
    err_d     = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (!DSI) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          shift_en = 1'b1;
          cnt_d    = CW'(1);
          state_d  = LOAD;
        end
      end

      LOAD: begin
        if (DSI) begin
          shift_en = 1'b1;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            pass_d  = '0;
            got_d   = 1'b0;
            state_d = SORT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d   = '0;
          armed_d = 1'b0;
          state_d = IDLE;
`ifdef MEDIAN_ERR_EN
          err_d   = 1'b1;
`endif
        end
      end

      SORT: begin
        shift_en = 1'b1;
`ifdef MEDIAN_ERR_EN
        err_d    = DSI;
`endif
        // First live entry of a pass seeds the running max; its slot is retired.
        if (live_q[0] && !got_q) begin
          cmp_d     = win_q[0];
          tail_val  = win_q[0];
          tail_live = 1'b0;
          got_d     = 1'b1;
        end else if (live_q[0]) begin
          cmp_d     = mce_max;
          tail_val  = mce_min;
          tail_live = 1'b1;
        end else begin
          tail_val  = win_q[0];
          tail_live = 1'b0;
        end

        if (cnt_q == LAST_IDX) begin
          cnt_d = '0;
          got_d = 1'b0;
          if (pass_q == LAST_PASS) begin
            state_d = OUT;
          end else begin
            pass_d = pass_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      OUT: begin
        dso_d   = 1'b1;
        do_d    = cmp_q;
        armed_d = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pass_q  <= '0;
      got_q   <= 1'b0;
      armed_q <= 1'b1;
      cmp_q   <= '0;
      do_q    <= '0;
      dso_q   <= 1'b0;
      live_q  <= '0;
      for (int i = 0; i < N; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      got_q   <= got_d;
      armed_q <= armed_d;
      cmp_q   <= cmp_d;
      do_q    <= do_d;
      dso_q   <= dso_d;
      live_q  <= live_d;
      for (int i = 0; i < N; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

`ifdef MEDIAN_ERR_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign ERR = err_q;
`endif

  assign DO  = do_q;
  assign DSO = dso_q;

endmodule

// File: tb/tb_median_seq.sv
// Randomized and directed bench for median_seq against a sort-based median model.
// Build with MEDIAN_ERR_EN defined to also exercise the ERR output.
module tb_median_seq;

  localparam int WIDTH = 8;
  localparam int N     = 9;
  localparam int P     = (N + 1) / 2;
  localparam int LAT   = P * N + 1;

  logic             CLK  = 1'b0;
  logic             nRST = 1'b0;
  logic [WIDTH-1:0] DI   = '0;
  logic             DSI  = 1'b0;
  logic [WIDTH-1:0] DO;
  logic             DSO;
`ifdef MEDIAN_ERR_EN
  logic             ERR;
  int               err_cnt = 0;
`endif

  median_seq #(.WIDTH(WIDTH), .N(N)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .DI   (DI),
    .DSI  (DSI),
    .DO   (DO),
    .DSO  (DSO)
`ifdef MEDIAN_ERR_EN
    ,
    .ERR  (ERR)
`endif
  );

  always #5 CLK = ~CLK;

  int   n_checks    = 0;
  int   n_errors    = 0;
  int   edge_cnt    = 0;
  int   dso_cnt     = 0;
  int   dso_edge    = 0;
  int   wide_cnt    = 0;
  int   frames_done = 0;
  int   last_edge   = 0;
  int   exp_last    = 0;
  logic prev_dso    = 1'b0;
  int   frame_vals [N];

  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  always @(negedge CLK) begin
    if (DSO) begin
      dso_cnt  = dso_cnt + 1;
      dso_edge = edge_cnt;
      if (prev_dso) wide_cnt = wide_cnt + 1;
    end
    prev_dso = DSO;
`ifdef MEDIAN_ERR_EN
    if (ERR) err_cnt = err_cnt + 1;
`endif
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: the ((N+1)/2)-th smallest value of the frame, duplicates counted.
  function automatic int ref_median();
    int q[$];
    for (int i = 0; i < N; i++) q.push_back(frame_vals[i]);
    q.sort();
    return q[(N - 1) / 2];
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // One DSI-low cycle to re-arm, then N consecutive samples.
  task automatic send_frame();
    DSI = 1'b0;
    tick(1);
    for (int i = 0; i < N; i++) begin
      DSI = 1'b1;
      DI  = WIDTH'(frame_vals[i]);
      tick(1);
    end
    last_edge = edge_cnt;
    DSI = 1'b0;
    DI  = '0;
  endtask

  task automatic run_frame(input string tag);
    int  start;
    int  exp;
    bit  seen;
    exp   = ref_median();
    start = dso_cnt;
    send_frame();
    check({tag, "_hold"}, 32'(DO), 32'(exp_last));
    seen = 1'b0;
    for (int i = 0; i < LAT + 20; i++) begin
      tick(1);
      if (dso_cnt != start) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_median"}, 32'(DO), 32'(exp));
      check({tag, "_latency"}, 32'(dso_edge - last_edge), 32'(LAT));
      frames_done++;
      exp_last = exp;
    end
    $display("frame %s median=%0d expected=%0d", tag, DO, exp);
  endtask

  initial begin
    int start;
    int mode;

    // Reset values
    tick(3);
    check("rst_do", 32'(DO), 32'd0);
    check("rst_dso", 32'(DSO), 32'd0);
    nRST = 1'b1;
    tick(2);

    for (int i = 0; i < N; i++) frame_vals[i] = i + 1;
    run_frame("ramp");

    for (int i = 0; i < N; i++) frame_vals[i] = N - i;
    run_frame("desc");
    for (int i = 0; i < N; i++) frame_vals[i] = 'hAA;
    run_frame("const_aa");

    frame_vals = '{255, 0, 255, 0, 255, 0, 255, 0, 128};
    run_frame("extremes");
    frame_vals = '{7, 7, 7, 3, 3, 3, 9, 9, 9};
    run_frame("dups");

    // Early abort after four samples
    start = dso_cnt;
`ifdef MEDIAN_ERR_EN
    begin
      int err_start;
      err_start = err_cnt;
`endif
    DSI = 1'b0;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      DSI = 1'b1;
      DI  = WIDTH'(200 + i);
      tick(1);
    end
    DSI = 1'b0;
    tick(100);
    check("abort_dso", 32'(dso_cnt - start), 32'd0);
    check("abort_do", 32'(DO), 32'(exp_last));
`ifdef MEDIAN_ERR_EN
      check("abort_err", 32'(err_cnt - err_start), 32'd1);
    end
`endif
    for (int i = 0; i < N; i++) frame_vals[i] = i + 1;
    run_frame("after_abort");

    // Reset pulse in the middle of SORT
    start = dso_cnt;
    send_frame();
    tick(20);
    #1 nRST = 1'b0;
    #1;
    check("midrst_do", 32'(DO), 32'd0);
    check("midrst_dso", 32'(DSO), 32'd0);
    #1 nRST = 1'b1;
    exp_last = 0;
    tick(100);
    check("midrst_no_dso", 32'(dso_cnt - start), 32'd0);
    run_frame("after_rst");

    // Random frames: full range, narrow range (many duplicates), extremes only
    for (int f = 0; f < 1000; f++) begin
      mode = int'($urandom_range(0, 2));
      for (int i = 0; i < N; i++) begin
        case (mode)
          0:       frame_vals[i] = int'($urandom_range(0, 255));
          1:       frame_vals[i] = int'($urandom_range(0, 3));
          default: frame_vals[i] = ($urandom_range(0, 2) == 0) ? 0 :
                                   (($urandom_range(0, 1) == 0) ? 128 : 255);
        endcase
      end
      tick(int'($urandom_range(0, 2)));
      run_frame($sformatf("rnd%0d", f));
    end

    check("dso_total", 32'(dso_cnt), 32'(frames_done));
    check("dso_width", 32'(wide_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/median_seq.md
Name: median_seq

Overview:
Sequential median filter for the median datapath.
- Serially captures an N-sample window on DI while DSI is high.
- Computes the median by repeated max-extraction passes through a single compare-exchange (min/max) unit.
- Presents the result on DO with a one-cycle DSO strobe.
- Sits downstream of the pixel source and reuses the existing MCE block as its only arithmetic element.

Parameters:
- WIDTH, 8, sample bit width.
- N, 9, window size; odd, N >= 3.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- DI  in  WIDTH  input sample, valid while DSI=1.
- DSI  in  1  input stream strobe; high for exactly N consecutive cycles per frame.
- DO  out  WIDTH  median result; held until the next DSO.
- DSO  out  1  one-cycle pulse, DO valid.

Behaviour:
- Clocking and reset: one clock CLK; reset nRST is asynchronous, active-low.
- Reset values: while nRST=0, DO=0, DSO=0, state=IDLE, sample count=0, window registers=0. Deassertion takes effect at the next CLK edge.
- States: IDLE, LOAD, SORT, OUT.
- IDLE:
  - DSI=1 at an edge captures DI as sample 0 and moves to LOAD.
  - A new frame is accepted only if DSI was sampled 0 at least one cycle after the previous OUT or abort. No re-trigger on a DSI held high.
- LOAD:
  - Each edge with DSI=1 shifts DI into the N-deep window and increments the count.
  - After the N-th sample, move to SORT on the same edge.
  - Further DSI=1 cycles are ignored until DSI returns low.
- Early abort: DSI=0 in LOAD before N samples discards the frame and returns to IDLE. No DSO is produced.
- SORT:
  - P=(N+1)/2 passes of exactly N cycles each, P*N cycles total (45 for N=9).
  - Pass k (k=0..P-1) rotates the N_remaining = N-k live entries through MCE. The running MAX is kept in the compare register and the MIN is written back.
  - At the end of pass k<P-1, the extracted maximum is marked discarded.
  - Idle slots in a pass, when N_remaining < N, rotate without compare.
  - The MAX produced by the final pass is the median, i.e. the ((N+1)/2)-th smallest value.
- OUT:
  - Exactly one cycle: DSO=1, DO=median. Then return to IDLE.
  - DO holds its value until the next OUT.
- Latency: DSO is high in the cycle following the (P*N+1)-th rising edge after the edge that captured the last sample (46 edges for N=9).
- DSI during SORT/OUT: ignored. A frame is never preempted.
- Comparison: unsigned. Ties are resolved without altering values; duplicates count individually.
- Reset mid-operation: nRST=0 in any state aborts immediately. DSO is not asserted for the interrupted frame.

Optional Feature:
MEDIAN_ERR_EN
- Defined:
  - Adds output port ERR (1 bit, reset 0).
  - ERR pulses high for one cycle on the edge after an early abort (DSI fell in LOAD with count < N).
  - ERR also pulses if DSI is sampled 1 during SORT.
- Undefined:
  - No ERR port.
  - Aborts are silent; DSI during SORT is ignored.

Decomposition:
- Package median_pkg:
  - localparam defaults WIDTH_DEF=8, N_DEF=9.
  - typedef sample_t (logic [WIDTH-1:0]).
  - typedef enum state_t {IDLE, LOAD, SORT, OUT}.
  - Function n_passes(N) = (N+1)/2.
- Sub-module: one instance of the existing MCE (A, B in; MAX, MIN out) as the compare-exchange unit.
- FSM, counters and window shift register live in median_seq.

Test Plan:
- DI=1,2,...,9 on 9 consecutive DSI cycles -> DSO exactly 46 edges after the last sample, DO=5, DSO width 1.
- DI=9,8,...,1, then DI=0xAA×9 back-to-back (DSI low 1 cycle between frames) -> DO=5, then DO=0xAA. DO holds 5 between the two strobes.
- DI={255,0,255,0,255,0,255,0,128} -> DO=128. Duplicates {7,7,7,3,3,3,9,9,9} -> DO=7.
- DSI high 4 cycles then low -> no DSO within 100 cycles, DO unchanged. ERR=1 one cycle if MEDIAN_ERR_EN. The next full frame 1..9 yields DO=5.
- nRST pulsed low for 2 ns at cycle 20 of SORT -> DO=0 and DSO=0 immediately, no DSO afterward. A subsequent frame 1..9 yields DO=5 at the nominal latency.
- 1000 random frames, compared against a sort-based reference model -> zero mismatches. DSO count equals the number of complete frames.
